elelock_keyscan: RTL and testbench
==================================

Name: elelock_keyscan

Overview:
Matrix keypad scanner for the electronic lock: the driving end of the lock's `tenkey`/`close` inputs. It strobes a 4x3 telephone keypad, synchronises and debounces the column returns, and presents one stable key as a one-hot 10-bit digit bus plus `close`/`star` levels. It runs directly on the internal oscillator clock (~53.2 MHz) and its outputs feed the lock's 50 Hz sampling logic.

Parameters:
- SCAN_DIV, 53200, osc_clk cycles per row slot (~1 ms); must be >= 4.
- DEBOUNCE_SCANS, 20, consecutive identical full-matrix frames required before the output changes; must be >= 1.

Ports:
- osc_clk  input  1  internal oscillator clock
- reset  input  1  asynchronous, active-high reset
- col_n  input  3  keypad column returns, active-low (pulled up), asynchronous to osc_clk
- row_n  output  4  keypad row drives, active-low, exactly one low at a time
- tenkey  output  10  debounced one-hot digit; bit k = digit k held; all-zero = no digit
- close  output  1  debounced '#' held
- star  output  1  debounced '*' held
- key_code  output  4  debounced code: 0-9 digit, 10 '*', 11 '#', 15 none

Behaviour:
- Reset is applied to every flop, asynchronous, active-high.
  - Reset values: `row_n` = 4'b1110; slot index 0; slot counter 0; `prev_code` 15; `stable_cnt` 0; `key_code` 15; `tenkey` 0; `close` 0; `star` 0; frame accumulator cleared.
- Keymap: row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = *,0,#. `col_n[0]` is the left column.
- Column sync: `col_n` passes through a 2-flop synchroniser. Only synchronised values are used.
- Slot timing:
  - The slot counter counts 0..SCAN_DIV-1.
  - In slot k, `row_n[k]` = 0 and the other rows = 1.
  - On the cycle where counter = SCAN_DIV-1, the synchronised columns are sampled into the frame accumulator, then the next edge advances k (3 wraps to 0) and updates `row_n`.
  - Slot length is exactly SCAN_DIV cycles; frame length is 4*SCAN_DIV cycles.
- Frame accumulation:
  - Track the number of pressed contacts seen this frame (saturating at 2) and the code of the last one.
  - At the end of slot 3, frame_code = that code if exactly one contact was seen, otherwise 15. Multi-key and none both give 15.
  - The accumulator is cleared for the next frame on the same edge.
- Debounce, evaluated on the frame-end edge:
  - If frame_code != `prev_code`: `prev_code` <= frame_code, `stable_cnt` <= 1.
  - Else if `stable_cnt` < DEBOUNCE_SCANS: `stable_cnt` increments.
  - The output register loads frame_code on the edge where the stable count reaches DEBOUNCE_SCANS. This includes the mismatch edge when DEBOUNCE_SCANS = 1.
  - `stable_cnt` saturates; the output is otherwise held.
- Output decode (registered alongside `key_code`, so all outputs change on the same edge):
  - `tenkey` = one-hot of `key_code` when 0..9, else 0.
  - `star` = (`key_code` == 10).
  - `close` = (`key_code` == 11).
  - Never more than one of `tenkey` / `star` / `close` is active.
- Release is debounced identically: code 15 must persist for DEBOUNCE_SCANS frames before the outputs clear.
- A key change to a different key goes directly old -> new after debounce, with no forced idle frame between.
- A bounce inside the debounce window restarts the count; the output is unchanged.
- Reset mid-frame or mid-debounce returns immediately to reset values. A key still held is re-reported only after DEBOUNCE_SCANS full frames following reset release.
- No combinational path from `col_n` to any output.

Test Plan:
All cases use SCAN_DIV=4, DEBOUNCE_SCANS=3, so a frame is 16 cycles.
- Reset: assert reset mid-slot -> `row_n` = 1110, `tenkey` = 0, `key_code` = 15 immediately. After release, `row_n` walks 1110, 1101, 1011, 0111, each held exactly 4 cycles, then repeats.
- Single press: pull `col_n[1]` low only while `row_n[1]` = 0 (key 5), from before frame 1 -> `tenkey` = 10'b00_0010_0000, `key_code` = 5, set on the edge ending frame 3 (48 cycles after frame 1 start) and not earlier.
- Bounce: key 5 for 2 frames, 1 frame open, then 3 frames closed -> `tenkey` stays 0 until the end of the 3rd closed frame, then = bit 5.
- Release and '#':
  - Release key 5 -> `tenkey` clears 3 frames later.
  - Press '#' (`col_n[2]`, row3) -> `close` = 1, `tenkey` = 0, `key_code` = 11 after 3 frames.
  - Press '*' -> `star` = 1 only.
- Multi-key: keys 1 and 9 held together -> the outputs report none (`key_code` 15). Releasing 9 -> `tenkey` bit 1 after 3 frames.
- Key change and reset: key 2 debounced, then switch directly to key 0 -> `tenkey` goes bit 2 -> bit 0 with no zero gap. Assert reset during the debounce of key 0 -> outputs 0, and re-reported only 3 frames after reset release.

Source files
------------

// File: rtl/elelock_keyscan.sv
// Keypad scanner for the electronic lock: strobes a 4x3 matrix one row per
// slot, synchronises the column returns, collects one frame's worth of
// contacts and debounces the frame result into registered key outputs.
module elelock_keyscan #(
  parameter int SCAN_DIV       = 53200,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       osc_clk,
  input  logic       reset,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] tenkey,
  output logic       close,
  output logic       star,
  output logic [3:0] key_code
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [3:0] NONE = 4'hF;

  logic [2:0]    col_s1, col_s2;
  logic [CW-1:0] slot_cnt;
  logic [1:0]    slot;
  logic [1:0]    hits, hits_nxt;
  logic [3:0]    last_code, code_nxt;
  logic [3:0]    prev_code, frame_code;
  logic [SW-1:0] stable_cnt, stable_nxt;
  logic          slot_end, frame_end, load;
  logic [9:0]    tenkey_nxt;

  // Keymap: rows 0..2 carry digits 1..9, row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
    if (r == 2'd3) begin
      case (c)
        2'd0:    return 4'd10;
        2'd1:    return 4'd0;
        default: return 4'd11;
      endcase
    end
    return {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
  endfunction

  assign slot_end  = (slot_cnt == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (slot == 2'd3);

  // Two-flop synchroniser on the asynchronous column returns (idle = pulled up).
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      col_s1 <= 3'b111;
      col_s2 <= 3'b111;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  // Slot timer and row strobe; the row advances on the edge after the sample cycle.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      slot     <= 2'd0;
      row_n    <= 4'b1110;
    end else if (slot_end) begin
      slot_cnt <= '0;
      slot     <= slot + 2'd1;
      row_n    <= ~(4'b0001 << (slot + 2'd1));
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  // Fold this slot's contacts into the running count (saturating at 2) and last code.
  always_comb begin
    hits_nxt = hits;
    code_nxt = last_code;
    for (int c = 0; c < 3; c++) begin
      if (!col_s2[c]) begin
        code_nxt = key_at(slot, 2'(c));
        if (hits_nxt != 2'd2) hits_nxt = hits_nxt + 2'd1;
      end
    end
    frame_code = (hits_nxt == 2'd1) ? code_nxt : NONE;
  end

  // Frame accumulator: updated on each sample cycle, cleared at frame end.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      hits      <= 2'd0;
      last_code <= NONE;
    end else if (frame_end) begin
      hits      <= 2'd0;
      last_code <= NONE;
    end else if (slot_end) begin
      hits      <= hits_nxt;
      last_code <= code_nxt;
    end
  end

  // Debounce count for the frame result; output loads when the count reaches the target.
  always_comb begin
    if (frame_code != prev_code)
      stable_nxt = SW'(1);
    else if (stable_cnt < SW'(DEBOUNCE_SCANS))
      stable_nxt = stable_cnt + SW'(1);
    else
      stable_nxt = stable_cnt;
    load = frame_end && (stable_nxt == SW'(DEBOUNCE_SCANS));
    for (int i = 0; i < 10; i++) tenkey_nxt[i] = (frame_code == 4'(i));
  end

  // Debounce history, updated once per frame.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      prev_code  <= NONE;
      stable_cnt <= '0;
    end else if (frame_end) begin
      prev_code  <= frame_code;
      stable_cnt <= stable_nxt;
    end
  end

  // Registered outputs: code and its decodes change together on the load edge.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      key_code <= NONE;
      tenkey   <= '0;
      star     <= 1'b0;
      close    <= 1'b0;
    end else if (load) begin
      key_code <= frame_code;
      tenkey   <= tenkey_nxt;
      star     <= (frame_code == 4'd10);
      close    <= (frame_code == 4'd11);
    end
  end

endmodule

// File: tb/tb_elelock_keyscan.sv
// Bench for the keypad scanner: a physical keypad model drives col_n from the
// set of held keys, and a frame-level model predicts the debounced outputs.
module tb_elelock_keyscan;

  logic       osc_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [9:0] tenkey;
  logic       close, star;
  logic [3:0] key_code;

  logic [11:0] held = '0;   // bit k = key with code k is pressed
  int n_checks = 0;
  int n_fail   = 0;

  always #5 osc_clk = ~osc_clk;

  elelock_keyscan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .osc_clk (osc_clk),
    .reset   (reset),
    .col_n   (col_n),
    .row_n   (row_n),
    .tenkey  (tenkey),
    .close   (close),
    .star    (star),
    .key_code(key_code)
  );

  function automatic int code_at(input int r, input int c);
    if (r < 3) return r * 3 + c + 1;
    if (c == 0) return 10;
    if (c == 1) return 0;
    return 11;
  endfunction

  function automatic int idx_of(input logic [11:0] v);
    for (int i = 0; i < 12; i++) if (v[i]) return i;
    return 15;
  endfunction

  // Keypad: a held key connects its row to its column.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!row_n[r] && held[code_at(r, c)]) col_n[c] = 1'b0;
  end

  // Frame-level model: one frame result per 16 cycles; output follows the
  // frame result once the last three results agree.
  int cyc    = 0;
  int m_code = 15;
  int fc_m;
  int hist[$];
  always @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      cyc = 0;
      hist.delete();
      m_code = 15;
    end else begin
      cyc++;
      if (cyc % 16 == 0) begin
        fc_m = ($countones(held) == 1) ? idx_of(held) : 15;
        hist.push_back(fc_m);
        if (hist.size() > 3) void'(hist.pop_front());
        if (hist.size() == 3 && hist[0] == hist[1] && hist[1] == hist[2]) m_code = fc_m;
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge osc_clk) begin
    check("row_n",    int'(row_n),  int'(4'b1111 ^ (4'b0001 << ((cyc / 4) % 4))));
    check("key_code", int'(key_code), m_code);
    check("tenkey",   int'(tenkey), (m_code < 10) ? (1 << m_code) : 0);
    check("star",     int'(star),   int'(m_code == 10));
    check("close",    int'(close),  int'(m_code == 11));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge osc_clk);
    #1;
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    tick(6);
    // Reset mid-slot returns to reset values at once.
    reset = 1'b1;
    #1;
    check("rst_row_n",  int'(row_n),    4'b1110);
    check("rst_tenkey", int'(tenkey),   0);
    check("rst_code",   int'(key_code), 15);
    held = 12'b1 << 5;
    tick(2);
    reset = 1'b0;
    // Single press of key 5 held from before frame 1.
    tick(4);  check("walk_row1", int'(row_n), 4'b1101);
    tick(4);  check("walk_row2", int'(row_n), 4'b1011);
    tick(4);  check("walk_row3", int'(row_n), 4'b0111);
    tick(4);  check("walk_wrap", int'(row_n), 4'b1110);
    tick(31); check("k5_early",  int'(key_code), 15);
    tick(1);  check("k5_code",   int'(key_code), 5);
    check("k5_tenkey", int'(tenkey), 10'b00_0010_0000);
    // Release.
    held = '0;
    tick(32); check("rel_hold", int'(tenkey), 10'b00_0010_0000);
    tick(16); check("rel_clr",  int'(tenkey), 0);
    // Bounce: 2 closed, 1 open, 3 closed.
    held = 12'b1 << 5; tick(32);
    held = '0;         tick(16);
    held = 12'b1 << 5; tick(32);
    check("bounce_hold", int'(tenkey), 0);
    tick(16); check("bounce_set", int'(tenkey), 10'b00_0010_0000);
    // '#' then '*' directly.
    held = 12'b1 << 11; tick(48);
    check("hash_close", int'(close), 1);
    check("hash_ten",   int'(tenkey), 0);
    check("hash_code",  int'(key_code), 11);
    held = 12'b1 << 10; tick(48);
    check("star_star",  int'(star), 1);
    check("star_close", int'(close), 0);
    check("star_code",  int'(key_code), 10);
    held = '0; tick(48);
    check("idle_code", int'(key_code), 15);
    // Multi-key 1+9, then release 9.
    held = (12'b1 << 1) | (12'b1 << 9); tick(64);
    check("multi_code", int'(key_code), 15);
    held = 12'b1 << 1; tick(32);
    check("one_early", int'(key_code), 15);
    tick(16); check("one_ten", int'(tenkey), 10'b00_0000_0010);
    // Key 2 then directly key 0.
    held = 12'b1 << 2; tick(48);
    check("k2_ten", int'(tenkey), 10'b00_0000_0100);
    held = 12'b1;      tick(32);
    check("k0_gap", int'(tenkey), 10'b00_0000_0100);
    tick(16); check("k0_ten", int'(tenkey), 10'b00_0000_0001);
    held = '0; tick(48);
    check("k0_rel", int'(key_code), 15);
    // Reset during the debounce of key 0.
    held = 12'b1; tick(21);
    reset = 1'b1;
    #1;
    check("rst2_code", int'(key_code), 15);
    check("rst2_ten",  int'(tenkey), 0);
    tick(3);
    reset = 1'b0;
    tick(47); check("rst2_early", int'(key_code), 15);
    tick(1);  check("rst2_code0", int'(key_code), 0);
    check("rst2_ten0", int'(tenkey), 10'b00_0000_0001);
    held = '0;
    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
